window_fifo_param: RTL and testbench



---
 rtl/window_fifo_param.sv | 104 ++++++++++
 tb/tb_window_fifo_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/window_fifo_param.sv
// Circular pixel store: variable-width pushes from the line buffer, sliding
// WIN_PIX window with per-pop stride, flush with optional zero left-pad.
module window_fifo_param #(
   parameter int unsigned PIX_W      = 16,
   parameter int unsigned PUSH_PIX   = 8,
   parameter int unsigned WIN_PIX    = 3,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned MAX_STRIDE = 2
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               start,
   input  logic                               row_end,
   input  logic                               pad_left,
   input  logic [1:0]                         stride,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [PUSH_PIX*PIX_W-1:0]          in_data,
   input  logic [$clog2(PUSH_PIX+1)-1:0]      in_npix,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [WIN_PIX*PIX_W-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0]         count
);

   localparam int unsigned NPIX_W = $clog2(PUSH_PIX + 1);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_P = (PTR_W + 1)'(DEPTH);

   logic [PIX_W-1:0]  store [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [NPIX_W-1:0] n_eff;
   logic [1:0]        s_eff;
   logic [CNT_W-1:0]  free_slots;
   logic [CNT_W-1:0]  push_n;
   logic [CNT_W-1:0]  pop_s;
   logic              flush;
   logic              push_fire;
   logic              pop_fire;

   // Modular add for DEPTH that need not be a power of two; k < DEPTH always.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W-1:0] k);
      logic [PTR_W:0] sum;
      sum = {1'b0, p} + {1'b0, k};
      if (sum >= DEPTH_P) sum = sum - DEPTH_P;
      return sum[PTR_W-1:0];
   endfunction

   assign flush = start | row_end;

   assign n_eff = (in_npix > NPIX_W'(PUSH_PIX)) ? NPIX_W'(PUSH_PIX) : in_npix;
   assign s_eff = (stride == 2'd0)              ? 2'd1 :
                  (stride > 2'(MAX_STRIDE))     ? 2'(MAX_STRIDE) : stride;

   assign free_slots = CNT_W'(DEPTH) - count;
   assign in_ready   = free_slots >= CNT_W'(PUSH_PIX);
   assign out_valid  = count >= CNT_W'(WIN_PIX);

   assign push_fire = in_valid & in_ready;
   assign pop_fire  = out_valid & out_ready;
   assign push_n    = push_fire ? CNT_W'(n_eff) : '0;
   assign pop_s     = pop_fire  ? CNT_W'(s_eff) : '0;

   always_comb begin
      out_data = '0;
      for (int unsigned j = 0; j < WIN_PIX; j++) begin
         out_data[j*PIX_W +: PIX_W] = store[ptr_add(rd_ptr, PTR_W'(j))];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         store  <= '{default: '0};
      end else if (flush) begin
         rd_ptr <= '0;
         if (pad_left) begin
            store[0] <= '0;
            wr_ptr   <= PTR_W'(1);
            count    <= CNT_W'(1);
         end else begin
            wr_ptr <= '0;
            count  <= '0;
         end
      end else begin
         if (push_fire) begin
            for (int unsigned i = 0; i < PUSH_PIX; i++) begin
               if (NPIX_W'(i) < n_eff)
                  store[ptr_add(wr_ptr, PTR_W'(i))] <= in_data[i*PIX_W +: PIX_W];
            end
            wr_ptr <= ptr_add(wr_ptr, PTR_W'(n_eff));
         end
         if (pop_fire)
            rd_ptr <= ptr_add(rd_ptr, PTR_W'(s_eff));
         count <= count + push_n - pop_s;
      end
   end

endmodule

// File: tb/tb_window_fifo_param.sv
// Directed plus random stimulus for window_fifo_param against a pixel-queue
// reference model.
module tb_window_fifo_param;

   localparam int unsigned PIX_W      = 16;
   localparam int unsigned PUSH_PIX   = 8;
   localparam int unsigned WIN_PIX    = 3;
   localparam int unsigned DEPTH      = 16;
   localparam int unsigned MAX_STRIDE = 2;

   logic                        clk = 1'b0;
   logic                        reset_n = 1'b0;
   logic                        start = 1'b0;
   logic                        row_end = 1'b0;
   logic                        pad_left = 1'b0;
   logic [1:0]                  stride = 2'd1;
   logic                        in_valid = 1'b0;
   logic                        in_ready;
   logic [PUSH_PIX*PIX_W-1:0]   in_data = '0;
   logic [3:0]                  in_npix = 4'd0;
   logic                        out_valid;
   logic                        out_ready = 1'b0;
   logic [WIN_PIX*PIX_W-1:0]    out_data;
   logic [4:0]                  count;

   int unsigned total  = 0;
   int unsigned passed = 0;
   logic [PIX_W-1:0] q[$];

   window_fifo_param #(
      .PIX_W(PIX_W), .PUSH_PIX(PUSH_PIX), .WIN_PIX(WIN_PIX),
      .DEPTH(DEPTH), .MAX_STRIDE(MAX_STRIDE)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .row_end(row_end),
      .pad_left(pad_left), .stride(stride), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_npix(in_npix),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock and apply the same inputs to the queue model.
   task automatic tick();
      int unsigned n, s;
      bit do_push, do_pop;
      n = (in_npix > 4'(PUSH_PIX)) ? PUSH_PIX : int'(in_npix);
      s = (stride == 0) ? 1 : ((stride > 2'(MAX_STRIDE)) ? MAX_STRIDE : int'(stride));
      do_push = in_valid && (int'(DEPTH) - q.size() >= int'(PUSH_PIX));
      do_pop  = out_ready && (q.size() >= int'(WIN_PIX));
      @(posedge clk);
      #1;
      if (!reset_n) q.delete();
      else if (start || row_end) begin
         q.delete();
         if (pad_left) q.push_back('0);
      end else begin
         if (do_pop) for (int unsigned k = 0; k < s; k++) void'(q.pop_front());
         if (do_push) for (int unsigned k = 0; k < n; k++) q.push_back(in_data[k*PIX_W +: PIX_W]);
      end
   endtask

   task automatic check_all(input string tag);
      logic [63:0] w;
      check({tag, ".count"}, 64'(count), 64'(q.size()));
      check({tag, ".in_ready"}, 64'(in_ready), 64'((int'(DEPTH) - q.size()) >= int'(PUSH_PIX)));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() >= int'(WIN_PIX)));
      if (q.size() >= int'(WIN_PIX)) begin
         w = '0;
         for (int unsigned j = 0; j < WIN_PIX; j++) w[j*PIX_W +: PIX_W] = q[j];
         check({tag, ".window"}, 64'(out_data), w);
      end
   endtask

   task automatic set_beat(input logic [15:0] base, input logic [3:0] n);
      for (int unsigned i = 0; i < PUSH_PIX; i++) in_data[i*PIX_W +: PIX_W] = base + 16'(i);
      in_npix = n;
   endtask

   task automatic do_flush(input logic pad);
      start = 1'b1; pad_left = pad; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      start = 1'b0;
   endtask

   initial begin
      // Reset held while a push is requested
      set_beat(16'h0001, 4'd8);
      in_valid = 1'b1;
      tick(); tick();
      check_all("reset");
      check("reset.out_data", 64'(out_data), 64'h0);
      in_valid = 1'b0;
      reset_n = 1'b1;

      // Padded row, stride 1
      do_flush(1'b1);
      check_all("pad_flush");
      stride = 2'd1;
      set_beat(16'h0001, 4'd8); in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      check_all("pad_push");
      check("pad_push.win", 64'(out_data), 64'h0002_0001_0000);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check_all("pad_pop");
      check("pad_pop.win", 64'(out_data), 64'h0003_0002_0001);

      // Stride 2 without padding
      do_flush(1'b0);
      stride = 2'd2;
      set_beat(16'h0001, 4'd8); in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      check_all("s2_push");
      out_ready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         tick();
         check_all("s2_pop");
      end
      out_ready = 1'b0;
      check("s2_end.count", 64'(count), 64'd2);

      // Fill to full, held push is refused, drain at stride 1
      do_flush(1'b0);
      set_beat(16'h0010, 4'd8); in_valid = 1'b1; tick();
      set_beat(16'h0018, 4'd8); tick();
      check_all("full");
      check("full.in_ready", 64'(in_ready), 64'd0);
      set_beat(16'h00A0, 4'd8); tick(); tick();
      in_valid = 1'b0;
      check_all("full_hold");
      stride = 2'd1; out_ready = 1'b1;
      for (int p = 0; p < 8; p++) begin
         tick();
         check_all("drain");
      end
      out_ready = 1'b0;
      check("drain.in_ready", 64'(in_ready), 64'd1);

      // Wrap: rd_ptr walks to slot 15 with slots 0/1 rewritten
      set_beat(16'h0020, 4'd8); in_valid = 1'b1; tick(); in_valid = 1'b0;
      out_ready = 1'b1;
      for (int p = 0; p < 7; p++) tick();
      out_ready = 1'b0;
      check_all("wrap");
      check("wrap.win", 64'(out_data), 64'h0021_0020_001F);

      // Simultaneous push and pop, then a short push alone
      do_flush(1'b0);
      set_beat(16'h0040, 4'd6); in_valid = 1'b1; tick();
      set_beat(16'h0050, 4'd5); stride = 2'd2; out_ready = 1'b1; tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check_all("push_pop");
      check("push_pop.count", 64'(count), 64'd9);
      do_flush(1'b0);
      set_beat(16'h0070, 4'd3); in_valid = 1'b1; tick(); in_valid = 1'b0;
      check_all("npix3");

      // row_end beats a concurrent push and pop
      do_flush(1'b0);
      set_beat(16'h0080, 4'd7); in_valid = 1'b1; tick();
      row_end = 1'b1; pad_left = 1'b1; out_ready = 1'b1; set_beat(16'h0090, 4'd8);
      tick();
      row_end = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      check_all("row_end");
      check("row_end.count", 64'(count), 64'd1);
      set_beat(16'h0060, 4'd8); in_valid = 1'b1; tick(); in_valid = 1'b0;
      check("row_end.win", 64'(out_data), 64'h0061_0060_0000);

      // Random traffic with clamps, flushes and occasional reset
      for (int c = 0; c < 400; c++) begin
         reset_n   = ($urandom_range(0, 199) != 0);
         start     = ($urandom_range(0, 39) == 0);
         row_end   = ($urandom_range(0, 59) == 0);
         pad_left  = 1'($urandom_range(0, 1));
         stride    = 2'($urandom_range(0, 3));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_npix   = 4'($urandom_range(0, 15));
         for (int unsigned i = 0; i < PUSH_PIX; i++) in_data[i*PIX_W +: PIX_W] = 16'($urandom);
         tick();
         check_all("rand");
      end

      // Reset overrides a push in the same cycle
      reset_n = 1'b1; start = 1'b0; row_end = 1'b0; out_ready = 1'b0;
      set_beat(16'h00B0, 4'd8); in_valid = 1'b1; tick();
      reset_n = 1'b0; tick();
      in_valid = 1'b0;
      check_all("final_reset");
      check("final_reset.count", 64'(count), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
